// File: rtl/spi_master_top.sv
// Register-mapped SPI master: one-byte full-duplex engine, four SPI modes, 8 active-low slave selects.
// Define SPI_MASTER_IRQ_EN to add an Irq output that pulses for one cycle when a transfer completes.
module spi_master_top (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] DataWr,
  input  logic [1:0] Addr,
  input  logic       Wr,
  input  logic       MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic [7:0] SS,
  output logic [7:0] DataRd
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic       Irq
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_next;
  logic [3:0] cpre;
  logic       cpha, cpol, en;
  logic [7:0] ssel, tx_sh, rx_sh, rx, rx_sh_next;
  logic [3:0] div_cnt, edge_cnt;
  logic       phase, mosi_q;
  logic       busy, start, toggle, finish, sample, shift, half_done;
  logic       wr_cfg, wr_ctrl, wr_ssel, wr_buf;

  assign wr_cfg  = Wr && (Addr == 2'd0);
  assign wr_ctrl = Wr && (Addr == 2'd1);
  assign wr_ssel = Wr && (Addr == 2'd2);
  assign wr_buf  = Wr && (Addr == 2'd3);
  assign busy    = (state == RUN);

  // phase counts SCK half-periods away from idle, so SCK always rests at CPOL
  assign SCK  = cpol ^ phase;
  assign MOSI = mosi_q;
  assign SS   = ssel;

  always_comb begin
    DataRd = 8'h00;
    case (Addr)
      2'd0: DataRd = {2'b00, cpol, cpha, cpre};
      2'd1: DataRd = {busy, 6'b000000, en};
      2'd2: DataRd = ssel;
      2'd3: DataRd = rx;
      default: DataRd = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Even edge_cnt values are leading SCK edges, odd values are trailing edges
  always_comb begin
    state_next = state;
    start      = 1'b0;
    toggle     = 1'b0;
    finish     = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    half_done  = (div_cnt == cpre);
    case (state)
      IDLE: begin
        if (wr_buf && en) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (half_done) begin
          toggle = 1'b1;
          finish = (edge_cnt == 4'd15);
          sample = cpha ? edge_cnt[0] : ~edge_cnt[0];
          shift  = cpha ? ~edge_cnt[0] : (edge_cnt[0] && !finish);
          if (finish) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    rx_sh_next = sample ? {rx_sh[6:0], MISO} : rx_sh;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cpre     <= 4'd0;
      cpha     <= 1'b0;
      cpol     <= 1'b0;
      en       <= 1'b0;
      ssel     <= 8'hFF;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      rx       <= 8'h00;
      div_cnt  <= 4'd0;
      edge_cnt <= 4'd0;
      phase    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      if (wr_cfg && !busy) {cpol, cpha, cpre} <= DataWr[5:0];
      if (wr_ctrl)         en <= DataWr[0];
      if (wr_ssel)         ssel <= DataWr;
      if (wr_buf && !busy) tx_sh <= DataWr;
      if (start) begin
        div_cnt  <= 4'd0;
        edge_cnt <= 4'd0;
        rx_sh    <= 8'h00;
        if (!cpha) mosi_q <= DataWr[7];
      end else if (busy) begin
        div_cnt <= half_done ? 4'd0 : div_cnt + 4'd1;
        rx_sh   <= rx_sh_next;
        if (toggle) begin
          phase    <= ~phase;
          edge_cnt <= edge_cnt + 4'd1;
        end
        // CPHA=0 already shows bit7, so its shifts expose the next lower bit
        if (shift) begin
          mosi_q <= cpha ? tx_sh[7] : tx_sh[6];
          tx_sh  <= {tx_sh[6:0], 1'b0};
        end
        if (finish) rx <= rx_sh_next;
      end
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  always_ff @(posedge Clk) begin
    if (Rst) Irq <= 1'b0;
    else     Irq <= finish;
  end
`endif

endmodule

// File: tb/tb_spi_master_top.sv
// Self-checking bench for spi_master_top: randomized bytes exchanged with a behavioural SPI slave.
// Irq checks are compiled in when SPI_MASTER_IRQ_EN is defined.
module tb_spi_master_top;

  logic       Clk = 1'b0;
  logic       Rst, Wr, MISO;
  logic [7:0] DataWr;
  logic [1:0] Addr;
  logic       SCK, MOSI;
  logic [7:0] SS, DataRd;
`ifdef SPI_MASTER_IRQ_EN
  logic       Irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  spi_master_top dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .DataWr (DataWr),
    .Addr   (Addr),
    .Wr     (Wr),
    .MISO   (MISO),
    .SCK    (SCK),
    .MOSI   (MOSI),
    .SS     (SS),
    .DataRd (DataRd)
`ifdef SPI_MASTER_IRQ_EN
    ,
    .Irq    (Irq)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the write applied
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    Addr   = a;
    DataWr = d;
    Wr     = 1'b1;
    @(negedge Clk);
    Wr     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    Addr = a;
    #1;
    d = DataRd;
  endtask

  // One full transfer against a mode-aware slave on SS[0]; inject_at>0 fires a
  // BUFFER write and a CONFIG write mid-transfer, both of which must be ignored.
  task automatic applyStimulus(input logic [7:0] cfg, input logic [7:0] tx,
                               input logic [7:0] slave_tx, input int inject_at);
    int         cpre, busy_cycles, toggles, last_toggle, bad_hp, irq_pulses;
    logic       cpha, cpol, prev_sck, leading, done, irq_at_fall;
    logic [7:0] slave_sh, slave_rx, rd;
    cpre = int'(cfg[3:0]);
    cpha = cfg[4];
    cpol = cfg[5];
    bus_write(2'd0, cfg);
    bus_write(2'd1, 8'h01);
    bus_write(2'd2, 8'hFE);
    checkOutput($sformatf("sck_idle_pre cfg=%02h", cfg), SCK, cpol);
    slave_sh = slave_tx;
    slave_rx = 8'h00;
    if (!cpha) MISO = slave_sh[7];
    prev_sck    = SCK;
    busy_cycles = 0;
    toggles     = 0;
    last_toggle = 0;
    bad_hp      = cpre + 1;
    irq_pulses  = 0;
    irq_at_fall = 1'b0;
    done        = 1'b0;
    bus_write(2'd3, tx);
    for (int c = 0; c < 16 * (cpre + 1) + 8 && !done; c++) begin
      Addr = 2'd1;
      Wr   = 1'b0;
      #1;
      if (c == 0 && !cpha) checkOutput($sformatf("mosi_first cfg=%02h", cfg), MOSI, tx[7]);
      if (SCK !== prev_sck) begin
        toggles++;
        if (c - last_toggle != cpre + 1) bad_hp = c - last_toggle;
        last_toggle = c;
        leading = (prev_sck === cpol);
        if (SS[0] == 1'b0) begin
          if (leading != cpha) slave_rx = {slave_rx[6:0], MOSI};
          else if (cpha) begin
            MISO     = slave_sh[7];
            slave_sh = slave_sh << 1;
          end else begin
            slave_sh = slave_sh << 1;
            MISO     = slave_sh[7];
          end
        end
        prev_sck = SCK;
      end
      if (DataRd[7] !== 1'b1) begin
        done = 1'b1;
`ifdef SPI_MASTER_IRQ_EN
        irq_at_fall = Irq;
        if (Irq === 1'b1) irq_pulses++;
`endif
      end else begin
        busy_cycles++;
`ifdef SPI_MASTER_IRQ_EN
        if (Irq === 1'b1) irq_pulses++;
`endif
        if (inject_at > 0 && c == inject_at) begin
          Addr = 2'd3; DataWr = 8'h00; Wr = 1'b1;
        end
        if (inject_at > 0 && c == inject_at + 2) begin
          Addr = 2'd0; DataWr = 8'h00; Wr = 1'b1;
        end
        @(negedge Clk);
      end
    end
    checkOutput($sformatf("transfer_done cfg=%02h", cfg), done, 1'b1);
    checkOutput($sformatf("busy_cycles cfg=%02h", cfg), busy_cycles, 16 * (cpre + 1));
    checkOutput($sformatf("sck_toggles cfg=%02h", cfg), toggles, 16);
    checkOutput($sformatf("half_period cfg=%02h", cfg), bad_hp, cpre + 1);
    checkOutput($sformatf("sck_idle_post cfg=%02h", cfg), SCK, cpol);
    checkOutput($sformatf("slave_rx cfg=%02h", cfg), slave_rx, tx);
    checkOutput($sformatf("mosi_hold cfg=%02h", cfg), MOSI, tx[0]);
    bus_read(2'd3, rd);
    checkOutput($sformatf("master_rx cfg=%02h", cfg), rd, slave_tx);
    bus_read(2'd0, rd);
    checkOutput($sformatf("config_rb cfg=%02h", cfg), rd, {2'b00, cfg[5:0]});
`ifdef SPI_MASTER_IRQ_EN
    @(negedge Clk);
    if (Irq === 1'b1) irq_pulses++;
    checkOutput($sformatf("irq_at_fall cfg=%02h", cfg), irq_at_fall, 1'b1);
    checkOutput($sformatf("irq_pulses cfg=%02h", cfg), irq_pulses, 1);
`endif
    bus_write(2'd2, 8'hFF);
  endtask

  initial begin
    logic [7:0] rd, rx_before;
    logic       prev_sck;
    int         toggles, busy_seen, irq_seen;
    int         cpres [4] = '{0, 1, 5, 13};

    Rst = 1'b1; Wr = 1'b0; Addr = 2'd0; DataWr = 8'h00; MISO = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset_ss", SS, 8'hFF);
    checkOutput("reset_sck", SCK, 1'b0);
    checkOutput("reset_mosi", MOSI, 1'b0);
    bus_read(2'd0, rd); checkOutput("reset_config", rd, 8'h00);
    bus_read(2'd1, rd); checkOutput("reset_ctrl", rd, 8'h00);
    bus_read(2'd2, rd); checkOutput("reset_sselec", rd, 8'hFF);
    bus_read(2'd3, rd); checkOutput("reset_buffer", rd, 8'h00);
`ifdef SPI_MASTER_IRQ_EN
    checkOutput("reset_irq", Irq, 1'b0);
`endif
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    applyStimulus(8'h00, 8'h5B, 8'hA5, 0);

    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 4; k++)
        applyStimulus(8'((m << 4) | cpres[k]), 8'($urandom), 8'($urandom), 0);

    applyStimulus(8'h0D, 8'h5B, 8'($urandom), 30);

    // EN=0: BUFFER write loads TX only
    bus_write(2'd1, 8'h00);
    bus_read(2'd3, rx_before);
    bus_write(2'd3, 8'h3C);
    prev_sck  = SCK;
    toggles   = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      bus_read(2'd1, rd);
      if (rd[7] === 1'b1) busy_seen++;
      if (SCK !== prev_sck) toggles++;
      prev_sck = SCK;
      @(negedge Clk);
    end
    checkOutput("en0_sck_toggles", toggles, 0);
    checkOutput("en0_busy", busy_seen, 0);
    bus_read(2'd3, rd);
    checkOutput("en0_rx_kept", rd, rx_before);
    applyStimulus(8'h00, 8'h3C, 8'($urandom), 0);

    // Reset abort mid-transfer
    bus_write(2'd0, 8'h25);
    bus_write(2'd1, 8'h01);
    bus_write(2'd2, 8'hFE);
    bus_write(2'd3, 8'($urandom));
    repeat (20) @(negedge Clk);
    bus_read(2'd1, rd);
    checkOutput("abort_busy_before", rd[7], 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    checkOutput("abort_ss", SS, 8'hFF);
    checkOutput("abort_sck", SCK, 1'b0);
    checkOutput("abort_mosi", MOSI, 1'b0);
    bus_read(2'd1, rd);
    checkOutput("abort_ctrl", rd, 8'h00);
    Rst = 1'b0;
    irq_seen = 0;
    toggles  = 0;
    prev_sck = SCK;
    for (int c = 0; c < 40; c++) begin
      #1;
`ifdef SPI_MASTER_IRQ_EN
      if (Irq === 1'b1) irq_seen++;
`endif
      if (SCK !== prev_sck) toggles++;
      prev_sck = SCK;
      @(negedge Clk);
    end
    checkOutput("abort_no_toggles", toggles, 0);
`ifdef SPI_MASTER_IRQ_EN
    checkOutput("abort_no_irq", irq_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_top.md
Name: spi_master_top

Overview:
Register-mapped SPI master with a one-byte full-duplex transfer engine and an 8-bit slave-select output register. A host writes and reads four 8-bit registers over a simple synchronous bus (Addr/Wr/DataWr/DataRd). The block generates SCK, MOSI and SS for up to 8 slaves and supports all four SPI modes with a programmable SCK prescaler. It sits between a host controller and external SPI slave devices.

Parameters:
- none; all configuration is done through registers.

Ports:
- Clk     in   1  system clock; all logic on rising edge
- Rst     in   1  synchronous, active-high reset
- DataWr  in   8  host write data
- Addr    in   2  register address
- Wr      in   1  write strobe; one register write per Clk cycle when high
- MISO    in   1  serial data from the selected slave
- SCK     out  1  SPI serial clock
- MOSI    out  1  serial data to the slave
- SS      out  8  slave selects, active low, one bit per slave
- DataRd  out  8  combinational read data for Addr

Behaviour:
- Register map:
  - 0 CONFIG: [3:0] CPre; [4] CPHA; [5] CPOL; [7:6] reserved, read 0.
  - 1 CTRL: [0] EN; [7] BUSY, read-only; others read 0.
  - 2 SSELEC: value driven directly onto SS.
  - 3 BUFFER: a write loads the TX byte; a read returns the last RX byte.
- Reset (Rst=1 at a Clk edge): CONFIG=0x00, EN=0, SSELEC=0xFF, TX=RX=0x00, BUSY=0, SCK=0, MOSI=0, SS=0xFF. Reset mid-transfer aborts immediately to these values.
- DataRd is a pure combinational mux of Addr. It has no read side effects.
- Transfer start:
  - A write to BUFFER with EN=1 and BUSY=0 loads the shifter.
  - BUSY=1 from the next cycle.
  - A BUFFER write while BUSY=1 is ignored.
  - A BUFFER write with EN=0 loads TX but starts no transfer.
- Writes to CONFIG while BUSY=1 are ignored. SSELEC is always writable.
- SCK timing:
  - Half-period = CPre+1 Clk cycles, so f_SCK = f_Clk / (2*(CPre+1)). CPre=0 gives f_Clk/2; CPre=15 gives f_Clk/32.
  - SCK idles at CPOL.
  - A transfer is exactly 8 SCK periods (16 half-periods, 16*(CPre+1) cycles of BUSY).
- Data order and sampling: MSB first.
  - CPHA=0: MOSI shows bit7 when BUSY rises. MISO is sampled on each leading edge. MOSI shifts on each trailing edge.
  - CPHA=1: MOSI shifts on each leading edge (bit7 at the first one). MISO is sampled on each trailing edge.
- End of transfer:
  - After the 16th half-period, SCK returns to CPOL and the received byte is written into RX.
  - BUSY clears in the same cycle. RX is valid when BUSY reads 0.
  - MOSI holds its last value until the next transfer.
- SS is never auto-driven by the engine. The host asserts and deasserts it via SSELEC.
- Clearing EN mid-transfer does not abort; the transfer completes.

Optional Feature:
- Macro: SPI_MASTER_IRQ_EN.
- With it defined: an extra output Irq (1 bit) pulses high for exactly one Clk cycle, in the cycle BUSY falls at the end of every completed transfer. Irq resets to 0 and does not pulse on reset abort.
- Without it: no Irq port; behaviour is otherwise identical.

Test Plan:
- Reset -> SS=0xFF, SCK=0, BUSY=0. DataRd reads 0x00 at addr 0, 0x00 at addr 1, 0xFF at addr 2, 0x00 at addr 3.
- CONFIG=0x00, CTRL=0x01, SSELEC=0xFE, BUFFER=0x5B; mode-0 slave model on SS[0] returns 0xA5 -> slave receives 0x5B, BUFFER reads 0xA5 after BUSY falls, BUSY lasted 16 cycles.
- Repeat with CONFIG=0x10/0x20/0x30 (modes 1-3), each at CPre 0, 1, 5 and 13 -> slave and master bytes match each time. SCK half-period = CPre+1 cycles; SCK idle = CPOL.
- CPre=13, BUFFER=0x5B, then BUFFER=0x00 written mid-transfer -> second write ignored, slave receives 0x5B, BUSY high for 224 cycles.
- CTRL=0x00, BUFFER=0x3C -> no SCK edges, BUSY stays 0. Then CTRL=0x01, BUFFER=0x3C -> transfer occurs.
- With SPI_MASTER_IRQ_EN: one transfer -> exactly one single-cycle Irq pulse coincident with BUSY falling. Rst asserted mid-transfer -> no Irq pulse, SS=0xFF.
